// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions used by both the display driver and the
// capture side: anode select codes, cathode patterns and small helpers.
package seven_segment_pkg;

  // Active-low anode selects, one low bit per digit position.
  typedef enum logic [3:0] {
    SEL_MIN_TENS = 4'b0111,
    SEL_MIN_ONES = 4'b1011,
    SEL_SEC_TENS = 4'b1101,
    SEL_SEC_ONES = 4'b1110
  } anode_sel_e;

  // Active-low cathode patterns, bit6=a .. bit0=g.
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } capture_state_e;

  // Only the four one-hot-low codes select a digit; everything else is
  // treated as "no select".
  function automatic logic anode_is_select(input logic [3:0] anode);
    return (anode == SEL_MIN_TENS) || (anode == SEL_MIN_ONES) ||
           (anode == SEL_SEC_TENS) || (anode == SEL_SEC_ONES);
  endfunction

  // Position index = index of the low anode bit (3=minutes tens .. 0=seconds ones).
  function automatic logic [1:0] anode_position(input logic [3:0] anode);
    logic [1:0] pos;
    pos = 2'd0;
    case (anode)
      SEL_MIN_TENS: pos = 2'd3;
      SEL_MIN_ONES: pos = 2'd2;
      SEL_SEC_TENS: pos = 2'd1;
      default:      pos = 2'd0;
    endcase
    return pos;
  endfunction

  // x*10 as (x<<3)+(x<<1).
  function automatic logic [6:0] times_ten(input logic [3:0] x);
    return {x, 3'b000} + {2'b00, x, 1'b0};
  endfunction

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational cathode-pattern to BCD decode.
//   pattern : active-low cathodes, bit6=a .. bit0=g
//   digit   : decoded BCD value (0 when not decimal)
//   valid   : pattern is one of the ten decimal glyphs
module seven_segment_pattern_decode
  import seven_segment_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers MM:SS from a multiplexed 4-digit seven-segment display bus.
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   anode_signals  : active-low digit select
//   display_out    : active-low cathodes, bit6=a .. bit0=g
//   minutes/seconds: last complete frame, binary
//   frame_valid    : one-cycle pulse when minutes/seconds update
//   pattern_error  : one-cycle pulse when a stable non-decimal glyph is accepted
//   stale          : high while no frame has completed for TIMEOUT_CYCLES
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 524288
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] anode_signals,
  input  logic [6:0] display_out,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       frame_valid,
  output logic       pattern_error,
  output logic       stale
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TIMEOUT_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [3:0]       anode_q, anode_d;
  logic [6:0]       cathode_q, cathode_d;
  capture_state_e   state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       sel_q, sel_d;
  logic [6:0]       pat_q, pat_d;
  logic [3:0][3:0]  digit_q, digit_d;
  logic [3:0]       mask_q, mask_d;
  logic [6:0]       minutes_q, minutes_d;
  logic [6:0]       seconds_q, seconds_d;
  logic             frame_valid_q, frame_valid_d;
  logic             pattern_error_q, pattern_error_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             stale_q, stale_d;

  logic       capture;
  logic [1:0] pos;
  logic [3:0] mask_next;
  logic [3:0] dec_digit;
  logic       dec_valid;

  seven_segment_pattern_decode u_decode (
    .pattern (cathode_q),
    .digit   (dec_digit),
    .valid   (dec_valid)
  );

  always_comb begin
    anode_d         = anode_signals;
    cathode_d       = display_out;
    state_d         = state_q;
    count_d         = count_q;
    sel_d           = sel_q;
    pat_d           = pat_q;
    digit_d         = digit_q;
    mask_d          = mask_q;
    minutes_d       = minutes_q;
    seconds_d       = seconds_q;
    frame_valid_d   = 1'b0;
    pattern_error_d = 1'b0;
    capture         = 1'b0;
    pos             = anode_position(anode_q);
    mask_next       = mask_q | (4'b0001 << pos);

    case (state_q)
      ST_IDLE: begin
        if (anode_is_select(anode_q)) begin
          state_d = ST_SETTLE;
          count_d = CNT_ONE;
          sel_d   = anode_q;
          pat_d   = cathode_q;
        end
      end
      ST_SETTLE: begin
        if (!anode_is_select(anode_q)) begin
          state_d = ST_IDLE;
        end else if ((anode_q != sel_q) || (cathode_q != pat_q)) begin
          count_d = CNT_ONE;
          sel_d   = anode_q;
          pat_d   = cathode_q;
        end else if (count_q >= STABLE_LAST) begin
          state_d = ST_HOLD;
          capture = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (anode_q != sel_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Only one capture per cycle, so the error and frame paths are exclusive
    // by construction; a bad glyph never reaches the mask update.
    if (capture) begin
      if (dec_valid) begin
        digit_d[pos] = dec_digit;
        if (mask_next == 4'b1111) begin
          mask_d        = '0;
          frame_valid_d = 1'b1;
          minutes_d     = times_ten(digit_d[3]) + {3'b000, digit_d[2]};
          seconds_d     = times_ten(digit_d[1]) + {3'b000, digit_d[0]};
        end else begin
          mask_d = mask_next;
        end
      end else begin
        pattern_error_d = 1'b1;
        mask_d          = '0;
      end
    end

    if (frame_valid_d)              timer_d = '0;
    else if (timer_q != TIMEOUT_MAX) timer_d = timer_q + TO_W'(1);
    else                            timer_d = timer_q;
    stale_d = (timer_d == TIMEOUT_MAX);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_q         <= '1;
      cathode_q       <= '1;
      state_q         <= ST_IDLE;
      count_q         <= '0;
      sel_q           <= '1;
      pat_q           <= '1;
      digit_q         <= '0;
      mask_q          <= '0;
      minutes_q       <= '0;
      seconds_q       <= '0;
      frame_valid_q   <= 1'b0;
      pattern_error_q <= 1'b0;
      timer_q         <= '0;
      stale_q         <= 1'b0;
    end else begin
      anode_q         <= anode_d;
      cathode_q       <= cathode_d;
      state_q         <= state_d;
      count_q         <= count_d;
      sel_q           <= sel_d;
      pat_q           <= pat_d;
      digit_q         <= digit_d;
      mask_q          <= mask_d;
      minutes_q       <= minutes_d;
      seconds_q       <= seconds_d;
      frame_valid_q   <= frame_valid_d;
      pattern_error_q <= pattern_error_d;
      timer_q         <= timer_d;
      stale_q         <= stale_d;
    end
  end

  assign minutes       = minutes_q;
  assign seconds       = seconds_q;
  assign frame_valid   = frame_valid_q;
  assign pattern_error = pattern_error_q;
  assign stale         = stale_q;

endmodule
